// File: rtl/seq_mult_16_if.sv
// Start/done handshake bundle for the sequential 16x16 multiplier.
interface seq_mult_16_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_16.sv
// Radix-2 shift-add unsigned multiplier, 16x16 -> 32, built around one
// kogge_stone_16 adder that is reused once per iteration.
module kogge_stone_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4;
   logic [16:0] c;

   // Prefix levels at span 1, 2, 4, 8; low bits keep their already-complete groups.
   assign g0 = a & b;
   assign p0 = a ^ b;
   assign g1 = g0 | (p0 & {g0[14:0], 1'b0});
   assign p1 = p0 & {p0[14:0], 1'b1};
   assign g2 = g1 | (p1 & {g1[13:0], 2'b00});
   assign p2 = p1 & {p1[13:0], 2'b11};
   assign g3 = g2 | (p2 & {g2[11:0], 4'h0});
   assign p3 = p2 & {p2[11:0], 4'hF};
   assign g4 = g3 | (p3 & {g3[7:0], 8'h00});
   assign p4 = p3 & {p3[7:0], 8'hFF};
   assign c    = {g4 | (p4 & {16{cin}}), cin};
   assign sum  = p0 ^ c[15:0];
   assign cout = c[16];
endmodule

module seq_mult_16 (
   input  logic               clk,
   input  logic               rst,
   seq_mult_16_if.slave       bus
);
   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    m_q, m_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    q_q, q_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [2*W-1:0]  product_q, product_d;

   logic [W-1:0]    add_sum;
   logic            add_cout;
   logic [W:0]      step;

   kogge_stone_16 u_add (
      .a    (acc_q),
      .b    (m_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Partial-product select: add M only when the current multiplier bit is set.
   assign step = q_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               m_d     = bus.a;
               q_d     = bus.b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = step[W:1];
            q_d   = {step[0], q_q[W-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               product_d = {step[W:1], step[0], q_q[W-1:1]};
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule
